adder9_sched: RTL
=================

ADDER9_SCHED -- requirements
Module: adder9_sched

Interface
REQ-001 MasterClock  in  1  single clock; all state updates on its rising edge.
REQ-002 RESET  in  1  synchronous, active-high reset; sampled on MasterClock rising edge only.
REQ-003 REQ_0, REQ_1, REQ_2  in  1 each  add request from requester n; held high until ACK_n seen.
REQ-004 XA_0, XA_1, XA_2  in  9 each  X operand of requester n; valid whenever REQ_n high.
REQ-005 YA_0, YA_1, YA_2  in  9 each  Y operand of requester n; valid whenever REQ_n high.
REQ-006 HOLD  in  1  stall; when high no new grant is issued.
REQ-007 ACK_0, ACK_1, ACK_2  out  1 each  one-cycle completion strobe to requester n.
REQ-008 Z  out  9  registered sum of the granted requester.
REQ-009 ZV  out  1  Z updated this cycle (high exactly when any ACK_n high).
REQ-010 ZSEL  out  2  index of requester owning Z (0..2).

Function
REQ-011 Block SHALL contain exactly one 9-bit adder shared by all three requesters, time-multiplexed one operation per cycle.
REQ-012 Sum SHALL be (XA_n + YA_n) mod 512; carry out of bit 8 discarded, no overflow flag.
REQ-013 Eligible set in a cycle SHALL be {n : REQ_n=1 and ACK_n=0}; requester whose ACK is high this cycle is masked.
REQ-014 With HOLD=0 and eligible set non-empty, grant SHALL go to first eligible index after round-robin pointer LAST, order LAST+1, LAST+2, LAST+3 (mod 3).
REQ-015 On grant to n at edge k: operands sampled at edge k; at edge k, Z<=sum, ZSEL<=n, ZV<=1, ACK_n<=1, LAST<=n; latency 1 cycle from REQ sample to ACK.
REQ-016 At most one ACK_n SHALL be high in any cycle; ACK_n high for exactly one cycle per grant.
REQ-017 With HOLD=1 or empty eligible set: ACK_* and ZV go low next cycle; Z, ZSEL, LAST hold.
REQ-018 HOLD=1 SHALL not cancel an ACK already registered (ACK from previous edge still shows for its cycle).
REQ-019 Requester keeping REQ_n high in the ACK cycle SHALL be treated as a new request from the following cycle; max rate per requester is one op per 2 cycles while others idle.
REQ-020 Fairness: with HOLD low, any continuously asserted REQ_n SHALL receive ACK_n within 3 grant cycles (≤3 cycles after first eligible).
REQ-021 Operand changes while REQ_n high and not granted SHALL be used as of the grant edge; no earlier capture.
REQ-022 Pointer wrap: LAST=2 followed by 0; all indices arithmetic mod 3; ZSEL value 3 never driven.
REQ-023 Z between grants SHALL remain stable (no glitch, no recompute).

Reset
REQ-024 RESET=1 at an edge SHALL force ACK_0..2=0, ZV=0, Z=0, ZSEL=0, LAST=2 (requester 0 first priority), regardless of REQ or HOLD.
REQ-025 Reset mid-operation SHALL discard any grant that would occur at that edge; no ACK in cycle after reset; requests still high are re-arbitrated from first edge with RESET=0.
REQ-026 RESET has priority over HOLD and all requests.

Verification
REQ-027 After reset, REQ_0=REQ_1=REQ_2=1 same cycle, XA_n=n+1, YA_n=10 -> ACK_0 (Z=11,ZSEL=0), then ACK_1 (Z=12,ZSEL=1), then ACK_2 (Z=13,ZSEL=2), one per cycle, ZV high 3 consecutive cycles.
REQ-028 REQ_1 only, XA_1=0x1FF, YA_1=0x002 -> next cycle ACK_1=1, Z=0x001, ZV=1; REQ_1 dropped -> ZV=0, Z holds 0x001.
REQ-029 REQ_0 held high continuously with REQ_2 high -> grants alternate 0,2,0,2; REQ_0 alone held high -> ACK_0 every other cycle.
REQ-030 REQ_0 and REQ_1 high, HOLD=1 for 4 cycles -> no ACK, Z/ZSEL unchanged; HOLD drops -> ACK_0 next cycle then ACK_1.
REQ-031 Grant to requester 1 issued, RESET asserted at following edge with REQ_2 high -> ACK all 0, Z=0, ZSEL=0, ZV=0; RESET low -> REQ_2 granted next cycle, Z=XA_2+YA_2.
REQ-032 Random 10k-cycle run vs. reference model: every ACK_n matches a REQ_n, Z equals mod-512 sum, no double ACK, fairness bound of REQ-020 never violated.

Source files
------------

// File: rtl/adder9_sched.sv
// adder9_sched: three-requester round-robin scheduler time-multiplexing one 9-bit adder
module adder9_sched (
  input  logic       MasterClock,
  input  logic       RESET,
  input  logic       REQ_0,
  input  logic       REQ_1,
  input  logic       REQ_2,
  input  logic [8:0] XA_0,
  input  logic [8:0] XA_1,
  input  logic [8:0] XA_2,
  input  logic [8:0] YA_0,
  input  logic [8:0] YA_1,
  input  logic [8:0] YA_2,
  input  logic       HOLD,
  output logic       ACK_0,
  output logic       ACK_1,
  output logic       ACK_2,
  output logic [8:0] Z,
  output logic       ZV,
  output logic [1:0] ZSEL
);
  logic [2:0] ack, elig;
  logic [1:0] last, n1, n2, gnt;
  logic       gnt_v;
  logic [8:0] xs, ys, sum;
  always_comb begin
    elig  = {REQ_2, REQ_1, REQ_0} & ~ack;
    n1    = (last == 2'd2) ? 2'd0 : last + 2'd1;
    n2    = (n1 == 2'd2) ? 2'd0 : n1 + 2'd1;
    gnt   = elig[n1] ? n1 : elig[n2] ? n2 : last;
    gnt_v = !HOLD && |elig;
    xs    = (gnt == 2'd0) ? XA_0 : (gnt == 2'd1) ? XA_1 : XA_2;
    ys    = (gnt == 2'd0) ? YA_0 : (gnt == 2'd1) ? YA_1 : YA_2;
    sum   = xs + ys;
  end
  always_ff @(posedge MasterClock) begin
    if (RESET) begin
      ack  <= 3'b000;
      Z    <= 9'd0;
      ZSEL <= 2'd0;
      last <= 2'd2;
    end else if (gnt_v) begin
      ack  <= 3'b001 << gnt;
      Z    <= sum;
      ZSEL <= gnt;
      last <= gnt;
    end else begin
      ack  <= 3'b000;
    end
  end
  assign ACK_0 = ack[0];
  assign ACK_1 = ack[1];
  assign ACK_2 = ack[2];
  assign ZV    = |ack;
endmodule
